pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor for wide operands.
- Splits the WIDTH-bit operation into STAGES equal slices. Each slice is resolved by group-CLA logic (GROUP-bit groups) in one cycle, and its carry is registered into the next slice.
- Uses a valid/ready handshake on both sides with full backpressure.
- Sits between the operand-issue logic and result consumers in the arithmetic datapath. Sustains one operation per cycle.

---
 rtl/pipelined_cla_adder_if.sv | 28 ++
 rtl/pipelined_cla_adder.sv | 140 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// The slave modport is the adder's view; master is the issuing/consuming side.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, f, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, f, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SW-bit slice per stage, with
// the slice carry registered into the next stage and operands skewed alongside.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input logic clk,
  input logic rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP;
  localparam int SK = (STAGES > 1) ? STAGES - 1 : 1;

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [WIDTH-1:0]  a_q  [SK];
  logic [WIDTH-1:0]  a_d  [SK];
  logic [WIDTH-1:0]  be_q [SK];
  logic [WIDTH-1:0]  be_d [SK];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic              advance;
  logic [WIDTH-1:0]  in_a  [STAGES];
  logic [WIDTH-1:0]  in_be [STAGES];
  logic [WIDTH-1:0]  in_s  [STAGES];
  logic [STAGES-1:0] in_c, in_v;
  logic [WIDTH-1:0]  part_s;
  logic [SW+1:0]     slice_r;
  logic              msb_c;

  // Returns {carry out, carry into slice MSB, sum} using GROUP-bit lookahead groups.
  function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] x,
                                               input logic [SW-1:0] y,
                                               input logic          ci);
    logic [SW-1:0] g, p;
    logic [SW:0]   c;
    logic [NG:0]   gc;
    logic          gg, gp;
    g     = x & y;
    p     = x ^ y;
    c     = '0;
    gc    = '0;
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        gp = gp & p[j*GROUP+i];
      end
      gc[j+1] = gg | (gp & gc[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c[j*GROUP] = gc[j];
      for (int i = 0; i < GROUP - 1; i++) begin
        c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
      end
    end
    c[SW] = gc[NG];
    return {c[SW], c[SW-1], p ^ c[SW-1:0]};
  endfunction

  // The whole pipe moves together; a stalled result freezes every stage behind it.
  always_comb begin
    advance = ~v_q[STAGES-1] | bus.out_ready;
    v_d     = v_q;
    c_d     = c_q;
    s_d     = s_q;
    a_d     = a_q;
    be_d    = be_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    part_s  = '0;
    slice_r = '0;
    msb_c   = 1'b0;

    in_a[0]  = bus.a;
    in_be[0] = bus.sub ? ~bus.b : bus.b;
    in_s[0]  = '0;
    in_c[0]  = bus.sub | bus.cin;
    in_v[0]  = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      in_a[k]  = a_q[k-1];
      in_be[k] = be_q[k-1];
      in_s[k]  = s_q[k-1];
      in_c[k]  = c_q[k-1];
      in_v[k]  = v_q[k-1];
    end

    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        slice_r = cla_slice(in_a[k][k*SW +: SW], in_be[k][k*SW +: SW], in_c[k]);
        part_s  = in_s[k];
        part_s[k*SW +: SW] = slice_r[SW-1:0];
        s_d[k]  = part_s;
        c_d[k]  = slice_r[SW+1];
        v_d[k]  = in_v[k];
        msb_c   = slice_r[SW];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_d[k]  = in_a[k];
        be_d[k] = in_be[k];
      end
      ovf_d  = msb_c ^ c_d[STAGES-1];
      zero_d = (s_d[STAGES-1] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      s_q    <= '{default: '0};
      a_q    <= '{default: '0};
      be_q   <= '{default: '0};
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v_q    <= v_d;
      c_q    <= c_d;
      s_q    <= s_d;
      a_q    <= a_d;
      be_q   <= be_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.f         = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder in three shapes: 32b/4 stages,
// 16b/2 stages and 32b/1 stage, driven in lockstep where no backpressure applies.
module tb_pipelined_cla_adder;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] f;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] f;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();
  pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_cla_adder_if #(.WIDTH(32)) bus1 ();

  pipelined_cla_adder #(.WIDTH(32), .STAGES(4), .GROUP(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  pipelined_cla_adder #(.WIDTH(16), .STAGES(2), .GROUP(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  pipelined_cla_adder #(.WIDTH(32), .STAGES(1), .GROUP(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  int          ready_mode = 0;
  logic        check_latency = 1'b0;
  exp_t        q32[$];
  exp_t        q16[$];
  exp_t        q1[$];
  logic        prev_stall [3];
  logic [31:0] prev_f     [3];
  logic [2:0]  prev_flags [3];
  vec_t        vec32 [9];
  vec_t        vec16 [9];

  always @(posedge clk) cycle++;

  // Random backpressure on the 4-stage instance only; the others always consume.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       bus32.out_ready = 1'b1;
      1:       bus32.out_ready = 1'($urandom_range(0, 1));
      default: bus32.out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input int w);
    exp_t        e;
    logic [63:0] mask, hmask, be, full, low;
    logic        ci;
    mask  = (64'd1 << w) - 64'd1;
    hmask = mask >> 1;
    be    = sub ? ~{32'd0, b} : {32'd0, b};
    be    = be & mask;
    ci    = sub ? 1'b1 : cin;
    full  = ({32'd0, a} & mask) + be + {63'd0, ci};
    low   = ({32'd0, a} & hmask) + (be & hmask) + {63'd0, ci};
    e.f    = full[31:0] & mask[31:0];
    e.cout = full[w];
    e.ovf  = low[w-1] ^ full[w];
    e.zero = (e.f == 32'd0);
    e.acc  = 0;
    return e;
  endfunction

  // Present one beat to the enabled instances and log expectations once accepted.
  task automatic applyStimulus(input logic [2:0] en, input vec_t v, input vec_t h);
    int   waited;
    exp_t e;
    bus32.in_valid = en[0];
    bus32.a = v.a; bus32.b = v.b; bus32.cin = v.cin; bus32.sub = v.sub;
    bus16.in_valid = en[1];
    bus16.a = h.a[15:0]; bus16.b = h.b[15:0]; bus16.cin = h.cin; bus16.sub = h.sub;
    bus1.in_valid = en[2];
    bus1.a = v.a; bus1.b = v.b; bus1.cin = v.cin; bus1.sub = v.sub;
    waited = 0;
    @(negedge clk);
    while (!((!en[0] || bus32.in_ready) && (!en[1] || bus16.in_ready) &&
             (!en[2] || bus1.in_ready)) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.f = v.f; e.cout = v.cout; e.ovf = v.ovf; e.zero = v.zero; e.acc = cycle;
      if (en[0]) q32.push_back(e);
      if (en[2]) q1.push_back(e);
      e.f = h.f; e.cout = h.cout; e.ovf = h.ovf; e.zero = h.zero;
      if (en[1]) q16.push_back(e);
    end
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    bus16.in_valid = 1'b0;
    bus1.in_valid  = 1'b0;
  endtask

  task automatic checkOutput(input int id, input logic ov, input logic ir, input logic ordy,
                             input logic [31:0] fv, input logic cv, input logic ovv,
                             input logic zv);
    exp_t  e;
    string tag;
    logic  empty;
    int    lat;
    tag = (id == 0) ? "s4w32" : (id == 1) ? "s2w16" : "s1w32";
    lat = (id == 0) ? 4 : (id == 1) ? 2 : 1;
    if (!rst_n) begin
      prev_stall[id] = 1'b0;
      return;
    end
    check({tag, "_in_ready"}, {31'd0, ir}, {31'd0, !(ov && !ordy)});
    if (prev_stall[id]) begin
      check({tag, "_hold_valid"}, {31'd0, ov}, 32'd1);
      check({tag, "_hold_f"}, fv, prev_f[id]);
      check({tag, "_hold_flags"}, {29'd0, cv, ovv, zv}, {29'd0, prev_flags[id]});
    end
    prev_stall[id] = ov && !ordy;
    prev_f[id]     = fv;
    prev_flags[id] = {cv, ovv, zv};
    if (ov && ordy) begin
      empty = 1'b1;
      case (id)
        0:       if (q32.size() > 0) begin e = q32.pop_front(); empty = 1'b0; end
        1:       if (q16.size() > 0) begin e = q16.pop_front(); empty = 1'b0; end
        default: if (q1.size() > 0)  begin e = q1.pop_front();  empty = 1'b0; end
      endcase
      if (empty) begin
        check({tag, "_unexpected_out"}, 32'd1, 32'd0);
      end else begin
        check({tag, "_f"}, fv, e.f);
        check({tag, "_cout_ovf_zero"}, {29'd0, cv, ovv, zv}, {29'd0, e.cout, e.ovf, e.zero});
        if (check_latency) check({tag, "_latency"}, cycle - e.acc, lat);
      end
    end
  endtask

  always @(negedge clk)
    checkOutput(0, bus32.out_valid, bus32.in_ready, bus32.out_ready,
                bus32.f, bus32.cout, bus32.ovf, bus32.zero);
  always @(negedge clk)
    checkOutput(1, bus16.out_valid, bus16.in_ready, bus16.out_ready,
                {16'd0, bus16.f}, bus16.cout, bus16.ovf, bus16.zero);
  always @(negedge clk)
    checkOutput(2, bus1.out_valid, bus1.in_ready, bus1.out_ready,
                bus1.f, bus1.cout, bus1.ovf, bus1.zero);

  task automatic waitDrain();
    int t;
    t = 0;
    while ((q32.size() != 0 || q16.size() != 0 || q1.size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (t >= 300) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    exp_t e;

    // a, b, cin, sub, f, cout, ovf, zero
    vec32[0] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0};
    vec32[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vec32[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vec32[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vec32[4] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vec32[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vec32[6] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vec32[7] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0};
    vec32[8] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 1'b0};

    vec16[0] = '{32'h0005, 32'h0003, 1'b1, 1'b0, 32'h0009, 1'b0, 1'b0, 1'b0};
    vec16[1] = '{32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1};
    vec16[2] = '{32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0};
    vec16[3] = '{32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0};
    vec16[4] = '{32'h0003, 32'h0005, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1'b0};
    vec16[5] = '{32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0, 1'b0};
    vec16[6] = '{32'hBEEF, 32'hBEEF, 1'b0, 1'b1, 32'h0000, 1'b1, 1'b0, 1'b1};
    vec16[7] = '{32'h1234, 32'h0FED, 1'b0, 1'b0, 32'h2221, 1'b0, 1'b0, 1'b0};
    vec16[8] = '{32'h8000, 32'h8000, 1'b1, 1'b0, 32'h0001, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus1.in_valid  = 1'b0; bus1.a  = '0; bus1.b  = '0; bus1.cin  = 1'b0; bus1.sub  = 1'b0;
    bus32.out_ready = 1'b1;
    bus16.out_ready = 1'b1;
    bus1.out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, bus32.out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, bus32.in_ready}, 32'd1);
    check("reset_f", bus32.f, 32'd0);
    check("reset_flags", {29'd0, bus32.cout, bus32.ovf, bus32.zero}, 32'd0);
    check("reset_s2_out_valid", {31'd0, bus16.out_valid}, 32'd0);
    check("reset_s1_out_valid", {31'd0, bus1.out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors, back-to-back, no backpressure");
    check_latency = 1'b1;
    for (int i = 0; i < 9; i++) applyStimulus(3'b111, vec32[i], vec16[i]);
    waitDrain();
    check_latency = 1'b0;

    $display("[TB] random stream with random backpressure");
    ready_mode = 1;
    for (int i = 0; i < 10; i++) begin
      v.a   = $urandom;
      v.b   = $urandom;
      v.cin = 1'($urandom_range(0, 1));
      v.sub = 1'($urandom_range(0, 1));
      e = model(v.a, v.b, v.cin, v.sub, 32);
      v.f = e.f; v.cout = e.cout; v.ovf = e.ovf; v.zero = e.zero;
      applyStimulus(3'b001, v, vec16[0]);
    end
    ready_mode = 0;
    waitDrain();

    $display("[TB] reset with beats in flight");
    ready_mode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) applyStimulus(3'b001, vec32[i], vec16[0]);
    check("stalled_out_valid", {31'd0, bus32.out_valid}, 32'd1);
    check("stalled_in_ready", {31'd0, bus32.in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'd0, bus32.out_valid}, 32'd0);
    check("async_reset_in_ready", {31'd0, bus32.in_ready}, 32'd1);
    check("async_reset_f", bus32.f, 32'd0);
    q32.delete();
    q16.delete();
    q1.delete();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_idle", {31'd0, bus32.out_valid}, 32'd0);
    check_latency = 1'b1;
    applyStimulus(3'b111, vec32[0], vec16[0]);
    applyStimulus(3'b111, vec32[6], vec16[6]);
    waitDrain();
    check_latency = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
